// File: rtl/cordic_sched_if.sv
// Bundle of request, response, CORDIC-facing and status signals for cordic_sched.
// The master side is the scheduler. The slave side is the requesters together with the CORDIC datapath.
interface cordic_sched_if #(
    parameter int N = 12,
    parameter int M = 24
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req_angle_a;
    logic [N-1:0] req_angle_b;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [M-1:0] rsp_sin;
    logic [M-1:0] rsp_cos;
    logic         cor_ce;
    logic [N-1:0] cor_angle;
    logic [M-1:0] cor_sin;
    logic [M-1:0] cor_cos;
    logic         busy;
    logic         grant_id;

    modport master (
        input  req_valid, req_angle_a, req_angle_b, rsp_ready, cor_sin, cor_cos,
        output req_ready, rsp_valid, rsp_sin, rsp_cos, cor_ce, cor_angle, busy, grant_id
    );

    modport slave (
        output req_valid, req_angle_a, req_angle_b, rsp_ready, cor_sin, cor_cos,
        input  req_ready, rsp_valid, rsp_sin, rsp_cos, cor_ce, cor_angle, busy, grant_id
    );
endinterface

// File: rtl/cordic_sched.sv
// Shares one CORDIC datapath between two requesters: arbitrate, hold ce/angle for LAT+1 cycles, capture, respond.
// Define CORDIC_SCHED_RR_EN for round-robin arbitration; the default build uses fixed priority (A first).
module cordic_sched #(
    parameter int N   = 12,
    parameter int M   = 24,
    parameter int LAT = 12
) (
    input  logic          CLK,
    input  logic          RST_N,
    cordic_sched_if.master bus
);
    localparam int CW = $clog2(LAT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAP, S_RESP} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_cor_angle;
    logic [M-1:0]  r_rsp_sin;
    logic [M-1:0]  r_rsp_cos;
    logic          r_grant_id;
    logic          w_winner;
    logic          w_accept;

`ifdef CORDIC_SCHED_RR_EN
    // r_rr_ptr names the requester that wins a tie; it flips away from each accepted requester.
    logic r_rr_ptr;

    always_comb begin
        if (bus.req_valid == 2'b11) w_winner = r_rr_ptr;
        else                        w_winner = ~bus.req_valid[0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)        r_rr_ptr <= 1'b0;
        else if (w_accept) r_rr_ptr <= ~w_winner;
    end
`else
    always_comb begin
        w_winner = ~bus.req_valid[0];
    end
`endif

    assign w_accept = (r_state == S_IDLE) && (bus.req_valid != 2'b00);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(LAT - 1)) w_state_next = S_CAP;
            S_CAP:   w_state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready[r_grant_id]) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // cnt leaves RUN at LAT-1, so it tops out at LAT and never wraps in CW bits.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt       <= '0;
            r_cor_angle <= '0;
            r_grant_id  <= 1'b0;
            r_rsp_sin   <= '0;
            r_rsp_cos   <= '0;
        end else begin
            if (w_accept) begin
                r_cor_angle <= w_winner ? bus.req_angle_b : bus.req_angle_a;
                r_grant_id  <= w_winner;
                r_cnt       <= '0;
            end
            if (r_state == S_RUN) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_CAP) begin
                r_rsp_sin <= bus.cor_sin;
                r_rsp_cos <= bus.cor_cos;
            end
        end
    end

    assign bus.req_ready = w_accept ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.cor_ce    = (r_state == S_RUN) || (r_state == S_CAP);
    assign bus.cor_angle = r_cor_angle;
    assign bus.rsp_valid = (r_state == S_RESP) ? (r_grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_sin   = r_rsp_sin;
    assign bus.rsp_cos   = r_rsp_cos;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.grant_id  = r_grant_id;
endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched: vector table plus hand-written backpressure and reset sequences.
// A behavioural CORDIC stand-in returns valid data only once ce has been held for LAT cycles.
module tb_cordic_sched;
    localparam int N   = 12;
    localparam int M   = 24;
    localparam int LAT = 12;
`ifdef CORDIC_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    cordic_sched_if #(.N(N), .M(M)) bus ();

    cordic_sched #(.N(N), .M(M), .LAT(LAT)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    function automatic logic [M-1:0] f_sin(input logic [N-1:0] a);
        logic signed [M-1:0] s;
        s = M'(signed'(a));
        return M'(s * 24'sd181);
    endfunction

    function automatic logic [M-1:0] f_cos(input logic [N-1:0] a);
        return {12'h010, a ^ 12'h5A5};
    endfunction

    // CORDIC stand-in: counts consecutive ce cycles and produces garbage unless the count is exactly LAT.
    int ce_run;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N)          ce_run <= 0;
        else if (bus.cor_ce) ce_run <= ce_run + 1;
        else                 ce_run <= 0;
    end
    assign bus.cor_sin = (ce_run == LAT) ? f_sin(bus.cor_angle) : 24'hDEAD00;
    assign bus.cor_cos = (ce_run == LAT) ? f_cos(bus.cor_angle) : 24'hBEEF00;

    typedef struct {
        int          id;
        logic [N-1:0] ang;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0]   v;
        logic [N-1:0] aa;
        logic [N-1:0] ab;
        int           exp_id;
        int           hold;
    } vec_t;
    vec_t tbl[7];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic txn(input logic [1:0] v, input logic [N-1:0] aa, input logic [N-1:0] ab,
                       input int exp_id, input int hold, input bit bpend, output int waited);
        logic [1:0]   exp_oh;
        logic [N-1:0] ang;
        logic [M-1:0] s0, c0;
        int           n;
        sb_t          e;
        exp_oh = (exp_id == 1) ? 2'b10 : 2'b01;
        bus.req_valid   = v;
        bus.req_angle_a = aa;
        bus.req_angle_b = ab;
        bus.rsp_ready   = 2'b00;
        #1;
        n = 0;
        while ((bus.req_ready & bus.req_valid) == 2'b00 && n < 50) begin
            step();
            n++;
        end
        waited = n;
        chk("req_ready_grant", 32'(bus.req_ready), 32'(exp_oh));
        ang   = (exp_id == 1) ? ab : aa;
        e.id  = exp_id;
        e.ang = ang;
        sbq.push_back(e);
        @(posedge CLK);
        step();
        n = 0;
        while (bus.cor_ce && n < 100) begin
            chk("cor_angle_stable", 32'(bus.cor_angle), 32'(ang));
            chk("req_ready_run", 32'(bus.req_ready), 32'd0);
            bus.req_angle_a = N'($urandom);
            bus.req_angle_b = N'($urandom);
            step();
            n++;
        end
        chk("ce_len", n, LAT + 1);
        bus.req_angle_a = aa;
        bus.req_angle_b = ab;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_oh));
        chk("grant_id", 32'(bus.grant_id), exp_id);
        chk("busy_resp", 32'(bus.busy), 32'd1);
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("rsp_sin", 32'(bus.rsp_sin), 32'(f_sin(e.ang)));
            chk("rsp_cos", 32'(bus.rsp_cos), 32'(f_cos(e.ang)));
        end
        $display("txn grant=%0d angle=%0d sin=%h cos=%h", exp_id, $signed(ang), bus.rsp_sin, bus.rsp_cos);
        s0 = bus.rsp_sin;
        c0 = bus.rsp_cos;
        if (bpend) bus.req_valid = 2'b10;
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = ~exp_oh;
            step();
            chk("rsp_valid_hold", 32'(bus.rsp_valid), 32'(exp_oh));
            chk("rsp_sin_hold", 32'(bus.rsp_sin), 32'(s0));
            chk("req_ready_resp", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = exp_oh;
        step();
        bus.rsp_ready = 2'b00;
        chk("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("rsp_cos_held", 32'(bus.rsp_cos), 32'(c0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int n;
        tbl[0] = '{2'b01, 12'd30,   12'd0,   0, 0};
        tbl[1] = '{2'b10, 12'd0,   -12'd120, 1, 2};
        for (int k = 2; k < 6; k++)
            tbl[k] = '{2'b11, 12'd45, 12'd90, RR ? (k % 2) : 0, 0};
        tbl[6] = '{2'b11, -12'd180, 12'd179, 0, 0};

        RST_N = 1'b0;
        bus.req_valid   = 2'b00;
        bus.req_angle_a = '0;
        bus.req_angle_b = '0;
        bus.rsp_ready   = 2'b00;
        #1;
        chk("rst_cor_ce", 32'(bus.cor_ce), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cor_angle", 32'(bus.cor_angle), 0);
        chk("rst_rsp_sin", 32'(bus.rsp_sin), 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        step();

        for (int k = 0; k < 7; k++)
            txn(tbl[k].v, tbl[k].aa, tbl[k].ab, tbl[k].exp_id, tbl[k].hold, 1'b0, w);

        // Backpressure: A response held 20 cycles while B waits, B accepted right after.
        txn(2'b01, 12'd10, 12'd0, 0, 20, 1'b1, w);
        txn(2'b10, 12'd10, -12'd45, 1, 0, 1'b0, w);
        chk("b_accept_latency", w, 0);

        // Reset in the middle of RUN with cnt at 5.
        bus.req_valid   = 2'b10;
        bus.req_angle_b = 12'd100;
        #1;
        n = 0;
        while (bus.req_ready != 2'b10 && n < 50) begin
            step();
            n++;
        end
        chk("rst_run_accept", 32'(bus.req_ready), 32'h2);
        @(posedge CLK);
        repeat (6) @(negedge CLK);
        bus.req_valid = 2'b00;
        RST_N = 1'b0;
        #1;
        chk("midrst_cor_ce", 32'(bus.cor_ce), 0);
        chk("midrst_cor_angle", 32'(bus.cor_angle), 0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("midrst_rsp_sin", 32'(bus.rsp_sin), 0);
        chk("midrst_rsp_cos", 32'(bus.rsp_cos), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_grant_id", 32'(bus.grant_id), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        step();
        txn(2'b11, -12'd60, 12'd77, 0, 0, 1'b0, w);

        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordic_sched.md
# cordic_sched

Arbiter and sequencer that shares one `cordic` datapath between two requesters, such as the calculator execute path and a display/self-test path. It accepts angle requests over valid/ready handshakes and grants one requester at a time. It holds the CORDIC enable and angle stable for the pipeline latency, captures sine/cosine, and returns them to the granted requester over a valid/ready response handshake.

## Interface
Parameters:
- `N`, 12: input angle width, signed degrees.
- `M`, 24: result width, matching the CORDIC output format (Q16.8).
- `LAT`, 12: number of cycles `cor_ce` is held before results are valid (CORDIC iterations + 2).

Ports (one clock; reset is asynchronous and active-low):
- `CLK` input 1: clock, all state on rising edge.
- `RST_N` input 1: asynchronous active-low reset.
- `req_valid` input 2: request valid; bit 0 = requester A, bit 1 = requester B.
- `req_ready` output 2: request accepted when `req_valid[i] && req_ready[i]`.
- `req_angle_a` input N: requester A angle, signed degrees.
- `req_angle_b` input N: requester B angle.
- `rsp_valid` output 2: response valid for the requester in that bit position.
- `rsp_ready` input 2: response consumed.
- `rsp_sin` output M: captured sine, shared by both requesters.
- `rsp_cos` output M: captured cosine, shared by both requesters.
- `cor_ce` output 1: CORDIC clock enable.
- `cor_angle` output N: angle driven to the CORDIC.
- `cor_sin` input M: CORDIC sine output.
- `cor_cos` input M: CORDIC cosine output.
- `busy` output 1: high in any state other than IDLE.
- `grant_id` output 1: index of the current or last granted requester.

## Operation
The block has four states: IDLE, RUN, CAP and RESP.

- **IDLE**
  - `req_ready[i]` is driven combinationally: 1 only for the arbitration winner, and only while its `req_valid` is high.
  - On acceptance: latch the winner's angle into `cor_angle`, set `grant_id`, clear `cnt`, go to RUN.
- **RUN**
  - `cor_ce`=1 and `cor_angle` is stable.
  - `cnt` increments each cycle.
  - When `cnt==LAT-1`, go to CAP.
- **CAP**
  - `cor_ce`=1 for this final cycle.
  - `rsp_sin`/`rsp_cos` <= `cor_sin`/`cor_cos`.
  - Go to RESP.
- **RESP**
  - `cor_ce`=0 and `rsp_valid[grant_id]`=1. The other `rsp_valid` bit is 0.
  - On `rsp_ready[grant_id]`, go to IDLE.
  - `rsp_ready` on the non-granted bit is ignored.

General rules:
- Requests are not accepted outside IDLE; `req_ready` is 0 in RUN, CAP and RESP.
- A requester may drop `req_valid` before it is accepted; no request is lost or duplicated.
- `rsp_sin`/`rsp_cos` are held from CAP until the next CAP. They are not cleared at the response handshake.
- `cnt` is `$clog2(LAT)+1` bits wide and does not wrap inside RUN.
- Angle values pass through unmodified. Normalisation is the CORDIC's job.
- Reset, at any time including mid-RUN, forces IDLE asynchronously. Reset values:
  - outputs: `cor_ce`=0, `cor_angle`=0, `rsp_valid`=0, `rsp_sin`=`rsp_cos`=0, `grant_id`=0, `busy`=0;
  - internal: `cnt`=0 and the round-robin pointer points to A.

## Timing
- Request accepted at rising edge k.
- RUN occupies cycles k+1 .. k+LAT.
- CAP occupies cycle k+LAT+1; results are registered at the end of CAP.
- `rsp_valid` rises at cycle k+LAT+2 and holds until the response handshake edge.
- Earliest next acceptance is the cycle after the response handshake (1 IDLE cycle).
- Back-to-back throughput is therefore one result per LAT+3 cycles with `rsp_ready` tied high.

## Configuration
Macro `CORDIC_SCHED_RR_EN`:
- **Defined:** round-robin arbitration.
  - The requester that was not granted last wins when both are valid.
  - The pointer updates only on acceptance.
  - Reset value of the pointer favours A.
- **Undefined:** fixed priority. A always wins when both are valid, so B can starve under continuous A traffic.
- Single-requester behaviour is identical in both builds.

## Test plan
1. **Single request:** A sends angle 30; model returns sin/cos.
   - Expect `req_ready[0]` at the accepting edge and `cor_ce` high for exactly LAT+1 cycles.
   - Expect `rsp_valid` = 2'b01 at k+LAT+2, and `rsp_sin`/`rsp_cos` equal to the model values at CAP.
2. **Simultaneous requests, RR build:** A=45 and B=90 held valid continuously.
   - Expect grant order A, B, A, B.
   - `rsp_valid` alternates 01/10 and `grant_id` toggles.
3. **Simultaneous requests, fixed-priority build:** same stimulus.
   - Expect A granted every time; `req_ready[1]` stays 0 while A is valid.
4. **Response backpressure:** hold `rsp_ready`=0 for 20 cycles in RESP.
   - `rsp_valid` and the data stay stable.
   - A new `req_valid` from B is not accepted.
   - Release `rsp_ready`: the response handshake completes, then B is accepted one cycle later.
5. **Reset mid-RUN:** assert `RST_N`=0 at `cnt`=5.
   - All outputs are 0 immediately, without waiting for a clock edge.
   - After release, a fresh A request (angle -60) completes with full latency.
6. **Angle stability:** while in RUN, change `req_angle_a`/`req_angle_b` every cycle.
   - `cor_angle` stays equal to the accepted value for all LAT+1 cycles.
